and_gate_sweep_ctrl: RTL and testbench

Sequencer that exercises a combinational logic gate (default: the two-input AND used in our Cello design flow) by stepping its inputs through every combination. It holds each combination for a programmable settle time, samples the gate output, and assembles a measured truth table. It compares that table against an expected one and reports pass/fail with a start/done handshake. It sits between a test or host controller and the gate instance, driving the gate inputs and observing its output.

---
 rtl/sweep_ctrl_pkg.sv | 19 +
 rtl/sweep_settle_timer.sv | 42 ++++
 rtl/and_gate_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_and_gate_sweep_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_ctrl_pkg.sv
// Shared definitions for the gate sweep controller.
// Holds the sequencer state encoding, the settle-counter width and the
// expected truth table of a two-input AND gate (bit i = output for input i).
package sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    // Settle counter width; covers SETTLE_CYCLES up to 255.
    localparam int unsigned CNT_W = 8;

    // Truth table of a two-input AND: only combination 3 (A=1,B=1) is high.
    localparam logic [3:0] AND2_EXPECTED = 4'b1000;

endpackage : sweep_ctrl_pkg

// File: rtl/sweep_settle_timer.sv
// Loadable down-counter that times how long each input combination is held.
// Ports:
//   clk, rst     - clock, synchronous active-high reset (count -> 0)
//   load         - load load_val on the next edge (has priority over dec)
//   load_val     - reload value
//   dec          - decrement by one; saturates at zero
//   zero         - count is zero (decoded from the count register)
module sweep_settle_timer
    import sweep_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: load wins, otherwise a saturating decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);

endmodule : sweep_settle_timer

// File: rtl/and_gate_sweep_ctrl.sv
// Sweeps a combinational gate through every input combination, holding each
// for SETTLE_CYCLES before capturing the gate output, then compares the
// measured truth table with EXPECTED.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   start        - sweep request, honoured only in IDLE
//   drive_in     - gate input vector (N_IN=2: in_A=drive_in[1], in_B=drive_in[0])
//   gate_out     - gate output under test
//   sample       - strobe in each cycle where gate_out is captured
//   busy         - sweep in progress (through the last SAMPLE)
//   done         - one-cycle completion pulse
//   truth_table  - measured table, bit i = output for combination i
//   match        - truth_table == EXPECTED, valid from done until next start
module and_gate_sweep_ctrl
    import sweep_ctrl_pkg::*;
#(
    parameter int unsigned N_IN          = 2,
    parameter int unsigned SETTLE_CYCLES = 8,
    localparam int unsigned TT_W         = 1 << N_IN,
    parameter logic [TT_W-1:0] EXPECTED  = TT_W'(AND2_EXPECTED)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] drive_in,
    input  logic            gate_out,
    output logic            sample,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] truth_table,
    output logic            match
);

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_e          state_q;
    logic [N_IN-1:0] drive_q;
    logic            sample_q;
    logic            busy_q;
    logic            done_q;
    logic [TT_W-1:0] tt_q;
    logic            match_q;

    logic            last_c;
    logic            tmr_load_c;
    logic            tmr_dec_c;
    logic            tmr_zero;
    logic [TT_W-1:0] tt_upd_c;

    // All-ones input vector is the terminal combination; no wrap mid-sweep.
    assign last_c = &drive_q;

    // Timer reloads on sweep start and on each non-final sample.
    always_comb begin
        tmr_load_c = 1'b0;
        tmr_dec_c  = 1'b0;
        if ((state_q == ST_IDLE) && start) begin
            tmr_load_c = 1'b1;
        end
        if ((state_q == ST_SAMPLE) && !last_c) begin
            tmr_load_c = 1'b1;
        end
        if (state_q == ST_SETTLE) begin
            tmr_dec_c = 1'b1;
        end
    end

    // Table with the current combination's result folded in, so the final
    // match compare sees the bit captured in this same cycle.
    always_comb begin
        tt_upd_c           = tt_q;
        tt_upd_c[drive_q]  = gate_out;
    end

    sweep_settle_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load_c),
        .load_val (SETTLE_LOAD),
        .dec      (tmr_dec_c),
        .zero     (tmr_zero)
    );

    // Sequencer and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            drive_q  <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tt_q     <= '0;
            match_q  <= 1'b0;
        end else begin
            sample_q <= 1'b0;
            done_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_SETTLE;
                        drive_q <= '0;
                        tt_q    <= '0;
                        match_q <= 1'b0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_zero) begin
                        state_q  <= ST_SAMPLE;
                        sample_q <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    tt_q <= tt_upd_c;
                    if (last_c) begin
                        match_q <= (tt_upd_c == EXPECTED);
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        drive_q <= drive_q + N_IN'(1);
                        state_q <= ST_SETTLE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign drive_in    = drive_q;
    assign sample      = sample_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = tt_q;
    assign match       = match_q;

endmodule : and_gate_sweep_ctrl

// File: tb/tb_and_gate_sweep_ctrl.sv
// Self-checking bench for and_gate_sweep_ctrl. Stimulus pushes expected
// sample cycles and completion records into queues; monitors pop and compare
// whenever the DUT strobes sample or done.
module tb_and_gate_sweep_ctrl;

    typedef struct {
        int         cyc;
        logic [7:0] tt;
        logic       m;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] drive_in;
    logic       gate_out;
    logic       sample;
    logic       busy;
    logic       done;
    logic [3:0] truth_table;
    logic       match;

    logic       start3 = 1'b0;
    logic [2:0] drive3;
    logic       gate3;
    logic       sample3;
    logic       busy3;
    logic       done3;
    logic [7:0] tt3;
    logic       match3;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   gmode = 0;
    logic tog = 1'b0;

    exp_t done_exp[$];
    exp_t done3_exp[$];
    int   samp_exp[$];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
    end

    // Gate models: 0 AND, 1 stuck-0, 2 AND only while sampled else toggling, 3 stuck-1.
    always_comb begin
        case (gmode)
            0:       gate_out = &drive_in;
            1:       gate_out = 1'b0;
            2:       gate_out = sample ? (&drive_in) : tog;
            default: gate_out = 1'b1;
        endcase
    end
    assign gate3 = |drive3;

    and_gate_sweep_ctrl u_dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .drive_in    (drive_in),
        .gate_out    (gate_out),
        .sample      (sample),
        .busy        (busy),
        .done        (done),
        .truth_table (truth_table),
        .match       (match)
    );

    and_gate_sweep_ctrl #(.N_IN(3), .SETTLE_CYCLES(1), .EXPECTED(8'hFE)) u_dut3 (
        .clk         (clk),
        .rst         (rst),
        .start       (start3),
        .drive_in    (drive3),
        .gate_out    (gate3),
        .sample      (sample3),
        .busy        (busy3),
        .done        (done3),
        .truth_table (tt3),
        .match       (match3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_evt(input string name);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Expectations for a default sweep accepted at edge a.
    task automatic push_sweep(input int a, input logic [3:0] tt, input logic m);
        exp_t e;
        for (int i = 0; i < 4; i++) samp_exp.push_back(a + 8 + 9 * i);
        e.cyc = a + 36;
        e.tt  = {4'b0, tt};
        e.m   = m;
        done_exp.push_back(e);
    endtask

    // Single-pulse sweep with the given gate model, then hold-value checks.
    task automatic do_sweep(input int mode, input logic [3:0] tt, input logic m);
        int a;
        gmode = mode;
        @(negedge clk);
        a = cyc + 1;
        push_sweep(a, tt, m);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_accept", busy, 1'b1);
        chk("drive_at_start", drive_in, 2'b00);
        repeat (40) @(negedge clk);
        chk("tt_hold", truth_table, tt);
        chk("match_hold", match, m);
        chk("drive_hold_ones", drive_in, 2'b11);
        chk("busy_idle", busy, 1'b0);
    endtask

    // Monitor for the default instance.
    always @(negedge clk) begin
        if (!rst) begin
            if (sample) begin
                if (samp_exp.size() == 0) fail_evt("sample_unexpected");
                else chk("sample_cycle", cyc, samp_exp.pop_front());
            end
            if (done) begin
                if (done_exp.size() == 0) begin
                    fail_evt("done_unexpected");
                end else begin
                    exp_t e;
                    e = done_exp.pop_front();
                    chk("done_cycle", cyc, e.cyc);
                    chk("done_tt", truth_table, e.tt);
                    chk("done_match", match, e.m);
                end
            end
        end
    end

    // Monitor for the N_IN=3 OR instance.
    always @(negedge clk) begin
        if (!rst && done3) begin
            if (done3_exp.size() == 0) begin
                fail_evt("done3_unexpected");
            end else begin
                exp_t e;
                e = done3_exp.pop_front();
                chk("done3_cycle", cyc, e.cyc);
                chk("done3_tt", tt3, e.tt);
                chk("done3_match", match3, e.m);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int   a;
        exp_t e;

        // Reset state.
        repeat (3) @(negedge clk);
        chk("rst_drive", drive_in, 2'b00);
        chk("rst_sample", sample, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tt", truth_table, 4'b0000);
        chk("rst_match", match, 1'b0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_sweep(0, 4'b1000, 1'b1);   // AND gate
        do_sweep(1, 4'b0000, 1'b0);   // stuck-at-0
        do_sweep(2, 4'b1000, 1'b1);   // noisy during settle

        // start held high: second sweep after one idle cycle.
        gmode = 0;
        @(negedge clk);
        a = cyc + 1;
        push_sweep(a, 4'b1000, 1'b1);
        push_sweep(a + 38, 4'b1000, 1'b1);
        start = 1'b1;
        repeat (38) @(negedge clk);
        chk("held_idle_busy", busy, 1'b0);
        chk("held_idle_done", done, 1'b0);
        @(negedge clk);
        chk("held_second_busy", busy, 1'b1);
        start = 1'b0;
        repeat (40) @(negedge clk);

        // Reset mid-sweep with stuck-1 gate so the table is non-zero before reset.
        gmode = 3;
        @(negedge clk);
        a = cyc + 1;
        samp_exp.push_back(a + 8);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        chk("pre_rst_tt", truth_table, 4'b0001);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_drive", drive_in, 2'b00);
        chk("mid_rst_tt", truth_table, 4'b0000);
        chk("mid_rst_done", done, 1'b0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        do_sweep(0, 4'b1000, 1'b1);

        // N_IN=3, SETTLE_CYCLES=1, OR gate.
        @(negedge clk);
        a = cyc + 1;
        e.cyc = a + 16;
        e.tt  = 8'hFE;
        e.m   = 1'b1;
        done3_exp.push_back(e);
        start3 = 1'b1;
        @(negedge clk);
        start3 = 1'b0;
        repeat (25) @(negedge clk);
        chk("or3_tt_hold", tt3, 8'hFE);

        chk("done_q_drained", done_exp.size(), 0);
        chk("sample_q_drained", samp_exp.size(), 0);
        chk("done3_q_drained", done3_exp.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_and_gate_sweep_ctrl
